// File: rtl/fmul_issue_ctrl.sv
// Issue controller sharing one fixed-latency pipelined FP multiplier between requesters:
// round-robin grant, per-register in-flight scoreboard, completion timing check, drain/halt FSM.
module fmul_issue_ctrl #(
   parameter int N_REQ  = 2,
   parameter int LAT    = 4,
   parameter int DEST_W = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_valid,
   output logic [N_REQ-1:0]        req_ready,
   input  logic [32*N_REQ-1:0]     req_op1,
   input  logic [32*N_REQ-1:0]     req_op2,
   input  logic [DEST_W*N_REQ-1:0] req_dest,
   input  logic                    drain_req,
   output logic                    drained,
   output logic                    mul_ena,
   output logic [31:0]             mul_op1,
   output logic [31:0]             mul_op2,
   output logic [DEST_W-1:0]       mul_dest,
   input  logic [31:0]             mul_result,
   input  logic                    mul_done,
   input  logic [DEST_W-1:0]       mul_out_dest,
   output logic                    wb_valid,
   output logic [DEST_W-1:0]       wb_dest,
   output logic [31:0]             wb_data,
   output logic [(1<<DEST_W)-1:0]  busy,
   output logic                    err
);
   localparam int NREG  = 1 << DEST_W;
   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   // Handshake: a requester transfers on a rising clk where req_valid[i] & req_ready[i];
   // it must hold valid, operands and dest stable until that edge.
   typedef enum logic [1:0] {
      S_RUN    = 2'd0,
      S_DRAIN  = 2'd1,
      S_HALTED = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              grant_en;
   logic [PTR_W-1:0]  rr_ptr;
   logic [PTR_W-1:0]  gnt_idx;
   logic [PTR_W-1:0]  cand;
   logic              gnt_any;
   logic [N_REQ-1:0]  elig;
   logic [NREG-1:0]   busy_eff;
   logic [NREG-1:0]   busy_nxt;
   logic [31:0]       sel_op1;
   logic [31:0]       sel_op2;
   logic [DEST_W-1:0] sel_dest;
   logic [LAT-1:0]    expect_q;
   logic              exp_tap;

   assign exp_tap = expect_q[LAT-1];

   // A register retiring this cycle is already free for a new issue.
   always_comb begin
      busy_eff = busy;
      if (mul_done) busy_eff[mul_out_dest] = 1'b0;
   end

   always_comb begin
      elig = '0;
      for (int i = 0; i < N_REQ; i++)
         elig[i] = req_valid[i] & ~busy_eff[req_dest[i*DEST_W +: DEST_W]];
   end

   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = PTR_W'((int'(rr_ptr) + k) % N_REQ);
         if (grant_en && !gnt_any && elig[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      sel_op1   = '0;
      sel_op2   = '0;
      sel_dest  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt_any && gnt_idx == PTR_W'(i)) begin
            req_ready[i] = 1'b1;
            sel_op1      = req_op1[i*32 +: 32];
            sel_op2      = req_op2[i*32 +: 32];
            sel_dest     = req_dest[i*DEST_W +: DEST_W];
         end
      end
   end

   // Set after clear so a same-edge retire/issue of one register leaves it busy.
   always_comb begin
      busy_nxt = busy;
      if (mul_done) busy_nxt[mul_out_dest] = 1'b0;
      if (gnt_any)  busy_nxt[sel_dest]     = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr   <= '0;
         mul_ena  <= 1'b0;
         mul_op1  <= '0;
         mul_op2  <= '0;
         mul_dest <= '0;
         busy     <= '0;
         expect_q <= '0;
         err      <= 1'b0;
         wb_valid <= 1'b0;
         wb_dest  <= '0;
         wb_data  <= '0;
      end else begin
         mul_ena <= gnt_any;
         if (gnt_any) begin
            mul_op1  <= sel_op1;
            mul_op2  <= sel_op2;
            mul_dest <= sel_dest;
            rr_ptr   <= (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
         end
         busy     <= busy_nxt;
         expect_q <= LAT'({expect_q, mul_ena});
         if ((mul_done != exp_tap) || (mul_done && !busy[mul_out_dest]))
            err <= 1'b1;
         wb_valid <= mul_done;
         wb_dest  <= mul_out_dest;
         wb_data  <= mul_result;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_RUN;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_RUN:    if (drain_req) state_nxt = S_DRAIN;
         S_DRAIN: begin
            if (!drain_req)                          state_nxt = S_RUN;
            else if (expect_q == '0 && !mul_ena)     state_nxt = S_HALTED;
         end
         S_HALTED: if (!drain_req) state_nxt = S_RUN;
         default:  state_nxt = S_RUN;
      endcase
   end

   always_comb begin
      grant_en = (state == S_RUN);
      drained  = (state == S_HALTED);
   end
endmodule

// File: tb/tb_fmul_issue_ctrl.sv
// Directed bench for fmul_issue_ctrl with a behavioural fixed-latency multiplier
// and an expected-writeback queue.
module tb_fmul_issue_ctrl;
   localparam int N_REQ  = 2;
   localparam int LAT    = 4;
   localparam int DEST_W = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid = '0;
   logic [1:0]  req_ready;
   logic [63:0] req_op1 = '0;
   logic [63:0] req_op2 = '0;
   logic [7:0]  req_dest = '0;
   logic        drain_req = 1'b0;
   logic        drained;
   logic        mul_ena;
   logic [31:0] mul_op1;
   logic [31:0] mul_op2;
   logic [3:0]  mul_dest;
   logic [31:0] mul_result;
   logic        mul_done;
   logic [3:0]  mul_out_dest;
   logic        wb_valid;
   logic [3:0]  wb_dest;
   logic [31:0] wb_data;
   logic [15:0] busy;
   logic        err;

   logic        inj_done = 1'b0;
   logic [3:0]  inj_dest = '0;
   logic        mon_en = 1'b1;
   logic [35:0] mon_e;
   logic [35:0] exp_q[$];
   int          total = 0;
   int          passed = 0;

   always #5 clk = ~clk;

   fmul_issue_ctrl #(.N_REQ(N_REQ), .LAT(LAT), .DEST_W(DEST_W)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_op1(req_op1), .req_op2(req_op2), .req_dest(req_dest),
      .drain_req(drain_req), .drained(drained), .mul_ena(mul_ena),
      .mul_op1(mul_op1), .mul_op2(mul_op2), .mul_dest(mul_dest),
      .mul_result(mul_result), .mul_done(mul_done), .mul_out_dest(mul_out_dest),
      .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data),
      .busy(busy), .err(err)
   );

   function automatic logic [31:0] fake_mul(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h3F9D70A4 && b == 32'h4015C28F) return 32'h4038346E;
      return a ^ {b[15:0], b[31:16]};
   endfunction

   function automatic logic [31:0] op1_of(input int i, input logic [3:0] d);
      return {16'h3F80, 8'(i), 4'h0, d};
   endfunction

   function automatic logic [31:0] op2_of(input int i, input logic [3:0] d);
      return {16'h4040, 4'h0, d, 8'(i)};
   endfunction

   // Behavioural multiplier: done appears LAT cycles after the enable cycle.
   typedef struct packed {
      logic        v;
      logic [3:0]  d;
      logic [31:0] r;
   } pipe_t;
   pipe_t pipe [LAT];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LAT; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= {mul_ena, mul_dest, fake_mul(mul_op1, mul_op2)};
         for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign mul_done     = pipe[LAT-1].v | inj_done;
   assign mul_out_dest = inj_done ? inj_dest : pipe[LAT-1].d;
   assign mul_result   = inj_done ? 32'hDEADBEEF : pipe[LAT-1].r;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (mon_en && !rst && wb_valid) begin
         if (exp_q.size() == 0) begin
            total++;
            $display("FAIL wb_unexpected: got dest 0x%0h data 0x%0h expected none", wb_dest, wb_data);
         end else begin
            mon_e = exp_q.pop_front();
            chk("wb_dest_data", {28'd0, wb_dest, wb_data}, {28'd0, mon_e});
         end
      end
   end

   task automatic set_req(input int i, input logic v, input logic [3:0] d,
                          input logic [31:0] a, input logic [31:0] b);
      req_valid[i]         = v;
      req_dest[i*4 +: 4]   = d;
      req_op1[i*32 +: 32]  = a;
      req_op2[i*32 +: 32]  = b;
   endtask

   task automatic push_exp(input logic [3:0] d, input logic [31:0] a, input logic [31:0] b);
      exp_q.push_back({d, fake_mul(a, b)});
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst       = 1'b1;
      req_valid = '0;
      drain_req = 1'b0;
      inj_done  = 1'b0;
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_empty;
      for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
      chk("wb_queue_empty", 64'(exp_q.size()), 64'd0);
   endtask

   typedef struct {
      logic [1:0] valid;
      logic [3:0] d0;
      logic [3:0] d1;
      logic [1:0] exp_ready;
   } vec_t;
   vec_t tbl [14];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      logic       prev_gnt;
      logic [3:0] prev_dest;

      tbl[0]  = '{2'b11, 4'd1, 4'd2, 2'b01};
      tbl[1]  = '{2'b11, 4'd3, 4'd2, 2'b10};
      tbl[2]  = '{2'b11, 4'd3, 4'd4, 2'b01};
      tbl[3]  = '{2'b11, 4'd5, 4'd4, 2'b10};
      tbl[4]  = '{2'b01, 4'd5, 4'd0, 2'b01};
      tbl[5]  = '{2'b01, 4'd6, 4'd0, 2'b01};
      tbl[6]  = '{2'b00, 4'd0, 4'd0, 2'b00};
      tbl[7]  = '{2'b10, 4'd0, 4'd7, 2'b10};
      tbl[8]  = '{2'b01, 4'd1, 4'd0, 2'b01};
      tbl[9]  = '{2'b10, 4'd0, 4'd1, 2'b00};
      tbl[10] = '{2'b11, 4'd8, 4'd1, 2'b01};
      tbl[11] = '{2'b10, 4'd0, 4'd1, 2'b00};
      tbl[12] = '{2'b10, 4'd0, 4'd1, 2'b00};
      tbl[13] = '{2'b10, 4'd0, 4'd1, 2'b10};

      rst = 1'b1;
      @(negedge clk);
      chk("rst_mul_ena", 64'(mul_ena), 64'd0);
      chk("rst_wb_valid", 64'(wb_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_drained", 64'(drained), 64'd0);
      chk("rst_mul_dest", 64'(mul_dest), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Round-robin, skip of a busy destination, WAW stall with same-cycle retire bypass.
      prev_gnt  = 1'b0;
      prev_dest = '0;
      for (int r = 0; r < 14; r++) begin
         @(negedge clk);
         chk("tbl_mul_ena", 64'(mul_ena), 64'(prev_gnt));
         if (prev_gnt) chk("tbl_mul_dest", 64'(mul_dest), 64'(prev_dest));
         set_req(0, tbl[r].valid[0], tbl[r].d0, op1_of(0, tbl[r].d0), op2_of(0, tbl[r].d0));
         set_req(1, tbl[r].valid[1], tbl[r].d1, op1_of(1, tbl[r].d1), op2_of(1, tbl[r].d1));
         #1;
         chk("tbl_ready", 64'(req_ready), 64'(tbl[r].exp_ready));
         prev_gnt = |tbl[r].exp_ready;
         if (tbl[r].exp_ready[0]) begin
            prev_dest = tbl[r].d0;
            push_exp(tbl[r].d0, op1_of(0, tbl[r].d0), op2_of(0, tbl[r].d0));
         end else if (tbl[r].exp_ready[1]) begin
            prev_dest = tbl[r].d1;
            push_exp(tbl[r].d1, op1_of(1, tbl[r].d1), op2_of(1, tbl[r].d1));
         end
      end
      @(negedge clk);
      req_valid = '0;
      chk("waw_mul_ena", 64'(mul_ena), 64'd1);
      chk("waw_mul_dest", 64'(mul_dest), 64'd1);
      chk("waw_busy_held", 64'(busy[1]), 64'd1);
      wait_empty();
      chk("tbl_err", 64'(err), 64'd0);

      // Single request with the reference product.
      do_reset();
      @(negedge clk);
      set_req(0, 1'b1, 4'd8, 32'h3F9D70A4, 32'h4015C28F);
      push_exp(4'd8, 32'h3F9D70A4, 32'h4015C28F);
      #1 chk("single_ready", 64'(req_ready), 64'b01);
      @(negedge clk);
      req_valid = '0;
      chk("single_mul_ena", 64'(mul_ena), 64'd1);
      chk("single_mul_op1", 64'(mul_op1), 64'h3F9D70A4);
      chk("single_mul_op2", 64'(mul_op2), 64'h4015C28F);
      chk("single_busy_set", 64'(busy), 64'h0100);
      for (int k = 2; k <= LAT + 1; k++) begin
         @(negedge clk);
         chk("single_wb_early", 64'(wb_valid), 64'd0);
      end
      @(negedge clk);
      chk("single_wb_valid", 64'(wb_valid), 64'd1);
      chk("single_wb_dest", 64'(wb_dest), 64'd8);
      chk("single_wb_data", 64'(wb_data), 64'h4038346E);
      chk("single_busy_clr", 64'(busy), 64'd0);
      chk("single_err", 64'(err), 64'd0);
      wait_empty();

      // Drain with three products in flight, then resume.
      do_reset();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         set_req(0, 1'b1, 4'(10 + k), op1_of(0, 4'(10 + k)), op2_of(0, 4'(10 + k)));
         push_exp(4'(10 + k), op1_of(0, 4'(10 + k)), op2_of(0, 4'(10 + k)));
         #1 chk("drain_issue_ready", 64'(req_ready), 64'b01);
      end
      @(negedge clk);
      req_valid = '0;
      drain_req = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         set_req(0, 1'b1, 4'd13, op1_of(0, 4'd13), op2_of(0, 4'd13));
         #1;
         chk("drain_no_grant", 64'(req_ready), 64'd0);
         chk("drain_not_yet", 64'(drained), 64'd0);
      end
      @(negedge clk);
      #1;
      chk("drain_drained", 64'(drained), 64'd1);
      chk("drain_halt_no_grant", 64'(req_ready), 64'd0);
      @(negedge clk);
      drain_req = 1'b0;
      #1;
      chk("drain_release_wait", 64'(req_ready), 64'd0);
      @(negedge clk);
      #1;
      chk("drain_resume_ready", 64'(req_ready), 64'b01);
      chk("drain_resume_run", 64'(drained), 64'd0);
      push_exp(4'd13, op1_of(0, 4'd13), op2_of(0, 4'd13));
      @(negedge clk);
      req_valid = '0;
      drain_req = 1'b1;
      @(negedge clk);
      drain_req = 1'b0;
      set_req(0, 1'b1, 4'd14, op1_of(0, 4'd14), op2_of(0, 4'd14));
      #1 chk("abort_in_drain", 64'(req_ready), 64'd0);
      @(negedge clk);
      #1 chk("abort_resume", 64'(req_ready), 64'b01);
      push_exp(4'd14, op1_of(0, 4'd14), op2_of(0, 4'd14));
      @(negedge clk);
      req_valid = '0;
      wait_empty();
      chk("drain_err", 64'(err), 64'd0);

      // Early completion, then completion for an idle register.
      do_reset();
      mon_en = 1'b0;
      @(negedge clk);
      set_req(0, 1'b1, 4'd3, op1_of(0, 4'd3), op2_of(0, 4'd3));
      #1 chk("err_issue_ready", 64'(req_ready), 64'b01);
      @(negedge clk);
      req_valid = '0;
      repeat (LAT - 1) @(negedge clk);
      chk("err_before", 64'(err), 64'd0);
      inj_done = 1'b1;
      inj_dest = 4'd3;
      @(negedge clk);
      inj_done = 1'b0;
      chk("err_early_done", 64'(err), 64'd1);
      repeat (6) @(negedge clk);
      chk("err_sticky", 64'(err), 64'd1);
      do_reset();
      chk("err_cleared_by_rst", 64'(err), 64'd0);
      @(negedge clk);
      inj_done = 1'b1;
      inj_dest = 4'd12;
      @(negedge clk);
      inj_done = 1'b0;
      chk("err_unbusy_done", 64'(err), 64'd1);
      repeat (3) @(negedge clk);
      chk("err_unbusy_sticky", 64'(err), 64'd1);
      do_reset();
      mon_en = 1'b1;

      // Asynchronous reset between edges with two products in flight.
      @(negedge clk);
      set_req(0, 1'b1, 4'd8, op1_of(0, 4'd8), op2_of(0, 4'd8));
      #1 chk("areset_issue0", 64'(req_ready), 64'b01);
      @(negedge clk);
      set_req(0, 1'b1, 4'd9, op1_of(0, 4'd9), op2_of(0, 4'd9));
      #1 chk("areset_issue1", 64'(req_ready), 64'b01);
      @(negedge clk);
      req_valid = '0;
      chk("areset_busy_before", 64'(busy), 64'h0300);
      chk("areset_ena_before", 64'(mul_ena), 64'd1);
      #2 rst = 1'b1;
      exp_q.delete();
      #1;
      chk("areset_busy", 64'(busy), 64'd0);
      chk("areset_mul_ena", 64'(mul_ena), 64'd0);
      chk("areset_wb_valid", 64'(wb_valid), 64'd0);
      chk("areset_err", 64'(err), 64'd0);
      chk("areset_drained", 64'(drained), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      set_req(0, 1'b1, 4'd8, op1_of(0, 4'd8), op2_of(0, 4'd8));
      #1 chk("areset_run_ready", 64'(req_ready), 64'b01);
      push_exp(4'd8, op1_of(0, 4'd8), op2_of(0, 4'd8));
      @(negedge clk);
      req_valid = '0;
      wait_empty();
      chk("areset_final_err", 64'(err), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
